// File: rtl/stopwatch_ctrl.sv
//============================================================================
// Module      : stopwatch_ctrl
// Description : RUN/PAUSED/ADJ mode sequencer for the stopwatch counters.
//               It turns divider ticks into single-cycle increment enables,
//               a counter clear and display blink qualifiers. Every output
//               is registered.
//               Defining the macro SATURATE_EN stops the count at 59:59
//               (HALT state) instead of letting it wrap.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module stopwatch_ctrl #(
    parameter bit START_PAUSED = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_4hz,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    input  logic       sec_max,
    input  logic       min_max,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       cnt_clr,
    output logic       running,
    output logic       blink_sec,
    output logic       blink_min,
    output logic [1:0] state
);

    localparam logic [1:0] S_PAUSED = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_ADJ    = 2'b10;
    localparam logic [1:0] S_HALT   = 2'b11;
    localparam logic [1:0] S_RESET  = START_PAUSED ? S_PAUSED : S_RUN;

    logic [1:0] r_state;
    logic       r_ret_run;
    logic       r_phase;
    logic       r_pause_prev;
    logic       r_rst_d;
    logic       r_sec_inc;
    logic       r_min_inc;
    logic       r_cnt_clr;
    logic       r_running;
    logic       r_blink_sec;
    logic       r_blink_min;

    logic [1:0] w_state_nxt;
    logic       w_ret_run_nxt;
    logic       w_pause_rise;
    logic       w_saturate;
    logic       w_phase_nxt;
    logic       w_sec_inc_nxt;
    logic       w_min_inc_nxt;
    logic       w_running_nxt;
    logic       w_blink_sec_nxt;
    logic       w_blink_min_nxt;

    assign w_pause_rise = pause_btn & ~r_pause_prev;

`ifdef SATURATE_EN
    assign w_saturate = (r_state == S_RUN) & tick_1hz & sec_max & min_max;
`else
    assign w_saturate = 1'b0;
`endif

    // State register, including the ADJ return target and pause edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RESET;
            r_ret_run    <= 1'b0;
            r_phase      <= 1'b0;
            r_pause_prev <= 1'b1;
            r_rst_d      <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_ret_run    <= w_ret_run_nxt;
            r_phase      <= w_phase_nxt;
            r_pause_prev <= pause_btn;
            r_rst_d      <= 1'b0;
        end
    end

    // Next-state logic; adj entry outranks every other transition
    always_comb begin
        w_state_nxt   = r_state;
        w_ret_run_nxt = r_ret_run;
        if (adj && (r_state != S_ADJ)) begin
            w_ret_run_nxt = (r_state == S_RUN);
            w_state_nxt   = S_ADJ;
        end else begin
            case (r_state)
                S_ADJ: begin
                    if (!adj) begin
                        w_state_nxt = r_ret_run ? S_RUN : S_PAUSED;
                    end else if (w_pause_rise) begin
                        w_ret_run_nxt = ~r_ret_run;
                    end
                end
                S_PAUSED: begin
                    if (w_pause_rise) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_saturate) begin
                        w_state_nxt = S_HALT;
                    end else if (w_pause_rise) begin
                        w_state_nxt = S_PAUSED;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // Output logic: strobes follow the pre-transition state, blink the next one
    always_comb begin
        w_sec_inc_nxt = 1'b0;
        w_min_inc_nxt = 1'b0;
        case (r_state)
            S_RUN: begin
                if (tick_1hz && !w_saturate) begin
                    w_sec_inc_nxt = 1'b1;
                    w_min_inc_nxt = sec_max;
                end
            end
            S_ADJ: begin
                if (tick_2hz) begin
                    w_sec_inc_nxt = sel;
                    w_min_inc_nxt = ~sel;
                end
            end
            default: begin
                w_sec_inc_nxt = 1'b0;
                w_min_inc_nxt = 1'b0;
            end
        endcase

        if (w_state_nxt == S_ADJ) begin
            w_phase_nxt = r_phase ^ ((r_state == S_ADJ) & tick_4hz);
        end else begin
            w_phase_nxt = 1'b0;
        end

        w_blink_min_nxt = (w_state_nxt == S_ADJ) & ~sel & w_phase_nxt;
        w_blink_sec_nxt = (w_state_nxt == S_ADJ) &  sel & w_phase_nxt;
        w_running_nxt   = (w_state_nxt == S_RUN);
    end

    // cnt_clr is held one extra cycle beyond reset via r_rst_d
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec_inc   <= 1'b0;
            r_min_inc   <= 1'b0;
            r_cnt_clr   <= 1'b1;
            r_running   <= (S_RESET == S_RUN);
            r_blink_sec <= 1'b0;
            r_blink_min <= 1'b0;
        end else begin
            r_sec_inc   <= w_sec_inc_nxt;
            r_min_inc   <= w_min_inc_nxt;
            r_cnt_clr   <= r_rst_d;
            r_running   <= w_running_nxt;
            r_blink_sec <= w_blink_sec_nxt;
            r_blink_min <= w_blink_min_nxt;
        end
    end

    assign sec_inc   = r_sec_inc;
    assign min_inc   = r_min_inc;
    assign cnt_clr   = r_cnt_clr;
    assign running   = r_running;
    assign blink_sec = r_blink_sec;
    assign blink_min = r_blink_min;
    assign state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
//============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Directed plus random bench for stopwatch_ctrl against a
//               behavioural mode model (default build, START_PAUSED=1).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, tick_2hz, tick_4hz;
    logic       pause_btn, adj, sel, sec_max, min_max;
    logic       sec_inc, min_inc, cnt_clr, running, blink_sec, blink_min;
    logic [1:0] state;

    stopwatch_ctrl #(.START_PAUSED(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .tick_4hz  (tick_4hz),
        .pause_btn (pause_btn),
        .adj       (adj),
        .sel       (sel),
        .sec_max   (sec_max),
        .min_max   (min_max),
        .sec_inc   (sec_inc),
        .min_inc   (min_inc),
        .cnt_clr   (cnt_clr),
        .running   (running),
        .blink_sec (blink_sec),
        .blink_min (blink_min),
        .state     (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sec_cnt, min_cnt, clr_cnt;
    string step_name = "init";

    // Model: mode 0 = paused, 1 = running, 2 = adjusting
    int m_mode;
    bit m_ret_run, m_phase, m_prev, m_rstd;
    bit m_clr, m_sinc, m_minc, m_bs, m_bm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s [%s] observed=%0h expected=%0h", tag, step_name, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit pr;
        int cur;
        if (rst) begin
            m_mode = 0; m_ret_run = 0; m_phase = 0; m_prev = 1; m_rstd = 1;
            m_clr = 1; m_sinc = 0; m_minc = 0; m_bs = 0; m_bm = 0;
        end else begin
            pr  = pause_btn && !m_prev;
            cur = m_mode;
            m_sinc = (cur == 1 && tick_1hz) || (cur == 2 && tick_2hz && sel);
            m_minc = (cur == 1 && tick_1hz && sec_max) || (cur == 2 && tick_2hz && !sel);
            if (adj && cur != 2) begin
                m_ret_run = (cur == 1);
                m_mode    = 2;
            end else if (cur == 2 && !adj) begin
                m_mode = m_ret_run ? 1 : 0;
            end else if (cur == 2 && pr) begin
                m_ret_run = !m_ret_run;
            end else if (pr) begin
                m_mode = 1 - cur;
            end
            if (m_mode == 2) begin
                if (cur == 2 && tick_4hz) m_phase = !m_phase;
            end else begin
                m_phase = 0;
            end
            m_bm   = (m_mode == 2) && !sel && m_phase;
            m_bs   = (m_mode == 2) &&  sel && m_phase;
            m_clr  = m_rstd;
            m_rstd = 0;
            m_prev = pause_btn;
        end
    endtask

    task automatic cyc();
        logic [1:0] exp_state;
        @(posedge clk);
        model_edge();
        #1;
        exp_state = 2'(m_mode);
        chk("state",     32'(state),     32'(exp_state));
        chk("running",   32'(running),   32'(m_mode == 1));
        chk("cnt_clr",   32'(cnt_clr),   32'(m_clr));
        chk("sec_inc",   32'(sec_inc),   32'(m_sinc));
        chk("min_inc",   32'(min_inc),   32'(m_minc));
        chk("blink_sec", 32'(blink_sec), 32'(m_bs));
        chk("blink_min", 32'(blink_min), 32'(m_bm));
        sec_cnt += int'(sec_inc === 1'b1);
        min_cnt += int'(min_inc === 1'b1);
        clr_cnt += int'(cnt_clr === 1'b1);
    endtask

    task automatic pulse1(); tick_1hz = 1; cyc(); tick_1hz = 0; cyc(); endtask
    task automatic pulse2(); tick_2hz = 1; cyc(); tick_2hz = 0; cyc(); endtask
    task automatic pulse4(); tick_4hz = 1; cyc(); tick_4hz = 0; cyc(); endtask
    task automatic press();  pause_btn = 1; cyc(); pause_btn = 0; cyc(); endtask
    task automatic clr_counts(); sec_cnt = 0; min_cnt = 0; clr_cnt = 0; endtask

    initial begin
        rst = 1; tick_1hz = 0; tick_2hz = 0; tick_4hz = 0;
        pause_btn = 0; adj = 0; sel = 0; sec_max = 0; min_max = 0;
        clr_counts();

        step_name = "reset";
        repeat (3) cyc();
        chk("rst_state", 32'(state), 32'h0);
        rst = 0;
        repeat (3) cyc();
        chk("clr_len", 32'(clr_cnt), 32'd4);
        clr_counts();
        repeat (5) pulse1();
        chk("paused_no_sec", 32'(sec_cnt), 32'd0);

        step_name = "run";
        press();
        chk("run_state", 32'(state), 32'h1);
        clr_counts();
        repeat (3) pulse1();
        chk("run_sec_cnt", 32'(sec_cnt), 32'd3);
        chk("run_min_cnt", 32'(min_cnt), 32'd0);

        step_name = "carry";
        clr_counts();
        sec_max = 1;
        pulse1();
        min_max = 1;
        pulse1();
        sec_max = 0; min_max = 0;
        chk("carry_sec", 32'(sec_cnt), 32'd2);
        chk("carry_min", 32'(min_cnt), 32'd2);
        chk("wrap_state", 32'(state), 32'h1);

        step_name = "adjust";
        clr_counts();
        adj = 1; sel = 0;
        cyc();
        chk("adj_state", 32'(state), 32'h2);
        for (int i = 0; i < 4; i++) begin
            pulse2();
            pulse1();
            pulse4();
        end
        chk("adj_min_cnt", 32'(min_cnt), 32'd4);
        chk("adj_sec_cnt", 32'(sec_cnt), 32'd0);
        clr_counts();
        sel = 1;
        cyc();
        pulse2();
        chk("adj_sel_sec", 32'(sec_cnt), 32'd1);
        chk("adj_sel_min", 32'(min_cnt), 32'd0);

        step_name = "adj_exit";
        pulse4();
        press();
        adj = 0;
        cyc();
        chk("exit_state", 32'(state), 32'h0);
        chk("exit_blink", 32'({blink_sec, blink_min}), 32'h0);

        step_name = "pause_tick";
        press();
        clr_counts();
        pause_btn = 1; tick_1hz = 1;
        cyc();
        pause_btn = 0; tick_1hz = 0;
        cyc();
        chk("pt_sec", 32'(sec_cnt), 32'd1);
        chk("pt_state", 32'(state), 32'h0);

        step_name = "held_through_rst";
        pause_btn = 1; rst = 1;
        repeat (2) cyc();
        rst = 0;
        repeat (3) cyc();
        chk("held_state", 32'(state), 32'h0);
        pause_btn = 0;
        cyc();

        step_name = "random";
        for (int n = 0; n < 4000; n++) begin
            rst      = ($urandom % 300) == 0;
            tick_1hz = ($urandom % 6) == 0;
            tick_2hz = ($urandom % 5) == 0;
            tick_4hz = ($urandom % 3) == 0;
            if (($urandom % 8) == 0)  pause_btn = ~pause_btn;
            if (($urandom % 30) == 0) adj = ~adj;
            if (($urandom % 12) == 0) sel = ~sel;
            sec_max  = ($urandom % 3) == 0;
            min_max  = ($urandom % 3) == 0;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
